// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter: the I-cache refill and D-cache ports share one memory port.
// Ties go to the D-side unless ARB_RR_EN is defined, in which case they alternate using last_gnt.
module mem_bus_arbiter (
    input  logic        clk,
    input  logic        clrn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_data,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        m_req,
    output logic        m_wr,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    output logic        busy,
    output logic [1:0]  gnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        IGNT = 2'b01,
        DGNT = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        m_wr_q, m_wr_d;
    logic        tie_to_d;
    logic        grant_i;
    logic        grant_d;

`ifdef ARB_RR_EN
    logic        last_gnt_q, last_gnt_d;
`endif

    // Winner selection is only consulted in IDLE; a tie is resolved by tie_to_d.
    always_comb begin
`ifdef ARB_RR_EN
        tie_to_d = ~last_gnt_q;
`else
        tie_to_d = 1'b1;
`endif
        grant_d = d_req & (~i_req | tie_to_d);
        grant_i = i_req & (~d_req | ~tie_to_d);
    end

    always_comb begin
        state_d   = state_q;
        m_addr_d  = m_addr_q;
        m_wr_d    = m_wr_q;
        m_wdata_d = m_wdata_q;
`ifdef ARB_RR_EN
        last_gnt_d = last_gnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d   = DGNT;
                    m_addr_d  = d_addr;
                    m_wr_d    = d_wr;
                    m_wdata_d = d_wdata;
                end else if (grant_i) begin
                    state_d   = IGNT;
                    m_addr_d  = i_addr;
                    m_wr_d    = 1'b0;
                    m_wdata_d = 32'd0;
                end
            end
            // A granted transaction ignores its req and runs until memory answers.
            IGNT: begin
                if (m_ready) begin
                    state_d = IDLE;
`ifdef ARB_RR_EN
                    last_gnt_d = 1'b0;
`endif
                end
            end
            DGNT: begin
                if (m_ready) begin
                    state_d = IDLE;
`ifdef ARB_RR_EN
                    last_gnt_d = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= IDLE;
            m_addr_q  <= 32'd0;
            m_wr_q    <= 1'b0;
            m_wdata_q <= 32'd0;
`ifdef ARB_RR_EN
            last_gnt_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            m_addr_q  <= m_addr_d;
            m_wr_q    <= m_wr_d;
            m_wdata_q <= m_wdata_d;
`ifdef ARB_RR_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    // Read data passes straight through; only the matching ready pulse qualifies it.
    assign i_data  = m_rdata;
    assign d_rdata = m_rdata;
    assign i_ready = (state_q == IGNT) && m_ready;
    assign d_ready = (state_q == DGNT) && m_ready;
    assign m_req   = (state_q != IDLE);
    assign busy    = (state_q != IDLE);
    assign gnt     = state_q;
    assign m_addr  = m_addr_q;
    assign m_wr    = m_wr_q;
    assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes predicted transactions, a negedge monitor pops them on ready.
// The reference model follows the arbitration rules at transaction level, honouring ARB_RR_EN when defined.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        clrn;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        i_ready;
    logic        d_req;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_req;
    logic        m_wr;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        busy;
    logic [1:0]  gnt;

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   exp_ready  = 0;
    int   got_ready  = 0;
    bit   model_last = 1'b0;

    mem_bus_arbiter dut (
        .clk     (clk),
        .clrn    (clrn),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_data  (i_data),
        .i_ready (i_ready),
        .d_req   (d_req),
        .d_wr    (d_wr),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ready (d_ready),
        .m_req   (m_req),
        .m_wr    (m_wr),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .busy    (busy),
        .gnt     (gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Tie goes to D unless round-robin is enabled, where it goes to whoever did not finish last.
    function automatic bit modelWinnerD(bit ireq, bit dreq);
        if (ireq && dreq) begin
`ifdef ARB_RR_EN
            return (model_last == 1'b0);
`else
            return 1'b1;
`endif
        end
        return dreq;
    endfunction

    // Monitor: decoupled from stimulus, checks invariants and pops the scoreboard on every ready.
    always @(negedge clk) begin
        checkOutput("ready_exclusive", 32'(i_ready & d_ready), 32'd0);
        checkOutput("busy_eq_mreq", 32'(busy), 32'(m_req));
        checkOutput("mreq_vs_gnt", 32'(m_req), 32'(gnt != 2'b00));
        if (i_ready || d_ready) begin
            got_ready++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL unexpected_ready: got i_ready=%0b d_ready=%0b, required no ready", i_ready, d_ready);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("ready_side_d", 32'(d_ready), 32'(e.is_d));
                checkOutput("ready_gnt", 32'(gnt), e.is_d ? 32'd2 : 32'd1);
                checkOutput("ready_m_addr", m_addr, e.addr);
                checkOutput("ready_m_wr", 32'(m_wr), 32'(e.wr));
                checkOutput("ready_m_wdata", m_wdata, e.wdata);
                checkOutput("ready_rdata", e.is_d ? d_rdata : i_data, e.rdata);
            end
        end
    end

    // Issue one transaction from IDLE (called at posedge+1); returns at posedge+1 of the following IDLE cycle.
    task automatic applyStimulus(input bit ireq, input bit dreq, input bit dwr,
                                 input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dwd,
                                 input int waits, input bit cancel);
        exp_t        e;
        bit          win_d;
        logic [31:0] rd;
        i_req   = ireq;
        d_req   = dreq;
        i_addr  = ia;
        d_addr  = da;
        d_wr    = dwr;
        d_wdata = dwd;
        rd      = $urandom;
        m_rdata = rd;
        m_ready = (waits == 0);
        if (!ireq && !dreq) begin
            @(posedge clk); #1;
            checkOutput("idle_no_req", 32'(gnt), 32'd0);
            return;
        end
        win_d   = modelWinnerD(ireq, dreq);
        e.is_d  = win_d;
        e.addr  = win_d ? da : ia;
        e.wr    = win_d ? dwr : 1'b0;
        e.wdata = win_d ? dwd : 32'd0;
        e.rdata = rd;
        exp_q.push_back(e);
        exp_ready++;
        @(posedge clk); #1;
        checkOutput("grant_gnt", 32'(gnt), win_d ? 32'd2 : 32'd1);
        checkOutput("grant_m_req", 32'(m_req), 32'd1);
        checkOutput("grant_m_addr", m_addr, e.addr);
        checkOutput("grant_m_wr", 32'(m_wr), 32'(e.wr));
        checkOutput("grant_m_wdata", m_wdata, e.wdata);
        for (int w = 0; w < waits; w++) begin
            if (cancel && w == 0) begin
                if (win_d) d_req = 1'b0;
                else       i_req = 1'b0;
            end
            if (win_d) begin
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_wr    = ~d_wr;
            end else begin
                i_addr = $urandom;
            end
            @(posedge clk); #1;
            checkOutput("wait_gnt_held", 32'(gnt), win_d ? 32'd2 : 32'd1);
            checkOutput("wait_m_addr_stable", m_addr, e.addr);
            checkOutput("wait_m_wdata_stable", m_wdata, e.wdata);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        if (win_d) d_req = 1'b0;
        else       i_req = 1'b0;
        m_ready    = 1'b0;
        model_last = win_d;
        checkOutput("done_idle_gnt", 32'(gnt), 32'd0);
        checkOutput("done_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        clrn    = 1'b0;
        i_req   = 1'b1;
        i_addr  = 32'h0;
        d_req   = 1'b0;
        d_wr    = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        m_rdata = 32'h0;
        m_ready = 1'b1;
        #1;
        checkOutput("reset_m_req", 32'(m_req), 32'd0);
        checkOutput("reset_gnt", 32'(gnt), 32'd0);
        checkOutput("reset_i_ready", 32'(i_ready), 32'd0);
        checkOutput("reset_m_addr", m_addr, 32'd0);
        @(posedge clk); #1;
        checkOutput("reset_held_gnt", 32'(gnt), 32'd0);
        i_req   = 1'b0;
        m_ready = 1'b0;
        clrn    = 1'b1;

        $display("[TB] single I read and D write with waits");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h200, 32'hDEADBEEF, 3, 1'b0);

        $display("[TB] reset mid-grant");
        d_req  = 1'b1;
        d_addr = 32'h300;
        @(posedge clk); #1;
        checkOutput("rst_pre_gnt", 32'(gnt), 32'd2);
        #2;
        clrn    = 1'b0;
        d_req   = 1'b0;
        m_ready = 1'b1;
        #1;
        checkOutput("rst_mid_m_req", 32'(m_req), 32'd0);
        checkOutput("rst_mid_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_mid_d_ready", 32'(d_ready), 32'd0);
        checkOutput("rst_mid_m_addr", m_addr, 32'd0);
        @(posedge clk); #1;
        m_ready    = 1'b0;
        clrn       = 1'b1;
        model_last = 1'b0;

        $display("[TB] ties with both requests held");
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, 1'b1, 1'($urandom), $urandom, $urandom, $urandom, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0, 0, 1'b0);

        $display("[TB] cancel mid-flight");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h500, 32'h0, 2, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 32'h0, 3, 1'b1);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 200; k++) begin
            int w;
            w = $urandom_range(0, 3);
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                          w, (w > 0) ? 1'($urandom) : 1'b0);
        end

        repeat (2) @(posedge clk);
        #1;
        checkOutput("all_ready_seen", 32'(got_ready), 32'(exp_ready));
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
